sdram_port_arbiter: RTL

Two-client arbiter and sequencer in front of `sdram_controller`. It accepts single-word read or write requests from two independent clients, for example a pixel fetcher and a host bus. It grants them round-robin and holds the controller's level-sensitive request until the controller acknowledges. It then returns the completion, plus read data, to the winning client as a one-cycle pulse.

---
 rtl/sdram_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Purpose: round-robin arbiter/sequencer granting two single-word clients access to one SDRAM controller.
// Latency: controller request rises on the grant edge; done/rdata reach the client 1 cycle after the controller ack.
// Backpressure: clients hold req until done; the controller request is held (level) until its matching ack, with no timeout.
module sdram_port_arbiter #(
    parameter int LAT_W = 16
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             ic0_req,
    input  logic             ic1_req,
    input  logic             ic0_we,
    input  logic             ic1_we,
    input  logic [21:0]      ic0_address,
    input  logic [21:0]      ic1_address,
    input  logic [15:0]      ic0_wdata,
    input  logic [15:0]      ic1_wdata,
    output logic             oc0_done,
    output logic             oc1_done,
    output logic [15:0]      oc0_rdata,
    output logic [15:0]      oc1_rdata,
    output logic             owrite_req,
    output logic [21:0]      owrite_address,
    output logic [15:0]      owrite_data,
    input  logic             iwrite_ack,
    output logic             oread_req,
    output logic [21:0]      oread_address,
    input  logic [15:0]      iread_data,
    input  logic             iread_ack,
    output logic             obusy,
    output logic             olast_owner,
    output logic [LAT_W-1:0] olast_latency
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             rr_last;     // client served last; the other one wins a tie
    logic             own_q;       // client owning the in-flight transaction
    logic             we_q;        // latched transaction type
    logic [LAT_W-1:0] lat_cnt;
    logic             grant_vld;
    logic             grant_sel;
    logic             grant_we;
    logic             ack_hit;

    // Arbitration decision, matching-ack detection and next-state logic.
    always_comb begin
        grant_vld = ic0_req | ic1_req;
        grant_sel = (ic0_req & ic1_req) ? ~rr_last : ic1_req;
        grant_we  = grant_sel ? ic1_we : ic0_we;
        ack_hit   = we_q ? iwrite_ack : iread_ack;
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (grant_vld) state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (ack_hit)   state_nxt = ARB_RESP;
            ARB_RESP:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iclk) begin
        if (ireset) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    // Registered datapath and outputs, updated alongside the state transitions.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            rr_last        <= 1'b1;
            own_q          <= 1'b0;
            we_q           <= 1'b0;
            lat_cnt        <= '0;
            oc0_done       <= 1'b0;
            oc1_done       <= 1'b0;
            oc0_rdata      <= '0;
            oc1_rdata      <= '0;
            owrite_req     <= 1'b0;
            owrite_address <= '0;
            owrite_data    <= '0;
            oread_req      <= 1'b0;
            oread_address  <= '0;
            obusy          <= 1'b0;
            olast_owner    <= 1'b0;
            olast_latency  <= '0;
        end else begin
            oc0_done <= 1'b0;
            oc1_done <= 1'b0;
            obusy    <= (state_nxt != ARB_IDLE);
            case (state)
                ARB_IDLE: begin
                    if (grant_vld) begin
                        own_q      <= grant_sel;
                        we_q       <= grant_we;
                        lat_cnt    <= LAT_ONE;
                        owrite_req <= grant_we;
                        oread_req  <= ~grant_we;
                        if (grant_we) begin
                            owrite_address <= grant_sel ? ic1_address : ic0_address;
                            owrite_data    <= grant_sel ? ic1_wdata   : ic0_wdata;
                        end else begin
                            oread_address  <= grant_sel ? ic1_address : ic0_address;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if (ack_hit) begin
                        owrite_req    <= 1'b0;
                        oread_req     <= 1'b0;
                        olast_latency <= lat_cnt;
                        olast_owner   <= own_q;
                        rr_last       <= own_q;
                        // Done and read data are both launched on the ack edge so
                        // they appear together in the single RESP cycle.
                        if (own_q) oc1_done <= 1'b1;
                        else       oc0_done <= 1'b1;
                        if (!we_q) begin
                            if (own_q) oc1_rdata <= iread_data;
                            else       oc0_rdata <= iread_data;
                        end
                    end else if (lat_cnt != LAT_MAX) begin
                        lat_cnt <= lat_cnt + LAT_ONE;
                    end
                end
                default: begin
                    // ARB_RESP: both controller requests already low; one idle cycle
                    // lets the controller settle back into its own idle state.
                end
            endcase
        end
    end

endmodule
